// File: rtl/sensor_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sensor_bus_arbiter_pkg
//
// Shared definitions for the sensor bus arbiter:
//   - arb_state_t      : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   - DEF_NREQ         : default number of requesters
//   - DEF_CMD_W        : default command word width
//   - DEF_DATA_W       : default read-data width
//   - DEF_TIMEOUT_CYC  : default engine completion timeout, in clk_clk cycles
//   - idx_width()      : width of a requester index (at least 1 bit)
// -----------------------------------------------------------------------------
package sensor_bus_arbiter_pkg;

  localparam int DEF_NREQ        = 4;
  localparam int DEF_CMD_W       = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 65535;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no owner, waiting for a request and a ready engine
    ISSUE = 2'd1,  // one-cycle start pulse to the engine
    WAIT  = 2'd2,  // engine busy, waiting for eng_done (or the timeout)
    RESP  = 2'd3   // one-cycle acknowledge to the owner
  } arb_state_t;

  // A single requester still needs a one-bit index so that port and
  // register widths never collapse to zero.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : sensor_bus_arbiter_pkg

// File: rtl/sensor_bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin selector. The search starts one position after
// the previous winner and wraps around, so the previous winner has the lowest
// priority on the next pick.
//
// Parameters:
//   NREQ    : number of requesters
//   IDX_W   : width of the requester index
// Ports:
//   req_i   in  [NREQ-1:0]   request vector
//   last_i  in  [IDX_W-1:0]  index of the previous winner
//   valid_o out              at least one request is set
//   idx_o   out [IDX_W-1:0]  index of the selected requester (0 if none)
// -----------------------------------------------------------------------------
module rr_pick
  import sensor_bus_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;

  // NOTE: every variable written in an always_comb gets a default at the top
  // of the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    // Walk offsets 1..NREQ from the previous winner; offset NREQ lands on the
    // previous winner itself, which therefore only wins when it is alone.
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last_i) + k) % NREQ);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/sensor_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sensor_bus_arbiter
//
// Shares one serial transaction engine (I2C or SPI master) between NREQ
// requesters. A request is granted round-robin, its command is latched and
// handed to the engine with a one-cycle start pulse, and the owner receives a
// one-cycle acknowledge carrying the read data once the engine reports done.
//
// Optional feature, compile-time macro ARB_TIMEOUT_EN:
//   defined   : a WAIT-state counter aborts the engine after TIMEOUT_CYC
//               cycles without eng_done; the owner is acknowledged with
//               req_err=1 and rsp_data=0. eng_done in the last cycle wins.
//   undefined : no counter, WAIT lasts until eng_done, eng_abort and req_err
//               are constant 0.
//
// Parameters: NREQ, CMD_W, DATA_W, TIMEOUT_CYC
// Ports:
//   clk_clk        in                 clock, rising edge
//   reset_reset_n  in                 asynchronous active-low reset
//   req_valid      in  [NREQ-1:0]     per-requester request, held until ack
//   req_cmd        in  [NREQ*CMD_W-1:0] requester i at [i*CMD_W +: CMD_W]
//   req_ack        out [NREQ-1:0]     one-hot, one-cycle completion pulse
//   req_err        out                qualifies req_ack: 1 = timed out
//   rsp_data       out [DATA_W-1:0]   read data, valid with req_ack
//   cur_grant      out [NREQ-1:0]     one-hot engine owner, 0 in IDLE
//   busy           out                high in every state except IDLE
//   eng_ready      in                 engine can accept a start
//   eng_start      out                one-cycle start pulse
//   eng_cmd        out [CMD_W-1:0]    latched command for the engine
//   eng_done       in                 one-cycle completion from the engine
//   eng_rdata      in  [DATA_W-1:0]   engine read data, valid with eng_done
//   eng_abort      out                one-cycle abort pulse on timeout
// -----------------------------------------------------------------------------
module sensor_bus_arbiter
  import sensor_bus_arbiter_pkg::*;
#(
  parameter int NREQ        = DEF_NREQ,
  parameter int CMD_W       = DEF_CMD_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*CMD_W-1:0] req_cmd,
  output logic [NREQ-1:0]       req_ack,
  output logic                  req_err,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [NREQ-1:0]       cur_grant,
  output logic                  busy,
  input  logic                  eng_ready,
  output logic                  eng_start,
  output logic [CMD_W-1:0]      eng_cmd,
  input  logic                  eng_done,
  input  logic [DATA_W-1:0]     eng_rdata,
  output logic                  eng_abort
);

  localparam int IDX_W = idx_width(NREQ);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  grant_idx_q;    // owner of the current transaction
  logic [IDX_W-1:0]  last_grant_q;   // owner of the last completed transaction
  logic [CMD_W-1:0]  cmd_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [CMD_W-1:0]  pick_cmd;
  logic [NREQ-1:0]   grant_onehot;
  logic              grant_now;      // IDLE accepts a request this cycle
  logic              timeout_hit;    // WAIT gives up this cycle

  // ---------------------------------------------------------------------------
  // Round-robin selection and command mux
  // ---------------------------------------------------------------------------
  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (req_valid),
    .last_i  (last_grant_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    pick_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_cmd = req_cmd[i*CMD_W +: CMD_W];
      end
    end
  end

  assign grant_now    = (state_q == IDLE) && pick_valid && eng_ready;
  assign grant_onehot = NREQ'(1) << grant_idx_q;

  // ---------------------------------------------------------------------------
  // Optional completion timeout
  // ---------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TO_W-1:0] to_cnt_q;

  // Counts WAIT cycles; the first WAIT cycle sees 0. Cleared in ISSUE so every
  // transaction starts from a fresh count.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      to_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      to_cnt_q <= '0;
    end else if (state_q == WAIT) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  // A completion arriving in the final cycle takes precedence over the abort.
  assign timeout_hit = (state_q == WAIT) && !eng_done &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
  logic [31:0] unused_timeout_cyc;

  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign timeout_hit        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order of the always blocks.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_now)               state_d = ISSUE;
      ISSUE:                                state_d = WAIT;
      WAIT:    if (eng_done || timeout_hit) state_d = RESP;
      RESP:                                 state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = 1'b0;
    eng_start = 1'b0;
    cur_grant = '0;
    req_ack   = '0;
    req_err   = 1'b0;
    unique case (state_q)
      IDLE: ;
      ISSUE: begin
        busy      = 1'b1;
        eng_start = 1'b1;
        cur_grant = grant_onehot;
      end
      WAIT: begin
        busy      = 1'b1;
        cur_grant = grant_onehot;
      end
      RESP: begin
        busy      = 1'b1;
        cur_grant = grant_onehot;
        req_ack   = grant_onehot;
        req_err   = err_q;
      end
      default: ;
    endcase
  end

  assign eng_abort = timeout_hit;
  assign eng_cmd   = cmd_q;
  assign rsp_data  = rdata_q;

  // ---------------------------------------------------------------------------
  // Transaction datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      grant_idx_q  <= '0;
      last_grant_q <= IDX_W'(NREQ - 1);  // requester 0 first after reset
      cmd_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Index and command are latched here, so a requester dropping
          // req_valid later cannot disturb the transaction in flight.
          if (grant_now) begin
            grant_idx_q <= pick_idx;
            cmd_q       <= pick_cmd;
          end
        end
        WAIT: begin
          if (eng_done) begin
            rdata_q <= eng_rdata;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        RESP: begin
          last_grant_q <= grant_idx_q;
        end
        default: ;
      endcase
    end
  end

endmodule : sensor_bus_arbiter

// File: tb/tb_sensor_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sensor_bus_arbiter
//
// Self-checking bench for sensor_bus_arbiter. The bench plays both the
// requesters and the serial engine. Expected winners come from a reference
// round-robin rule over the bench's own pending-request vector, expected
// commands and read data from the values the bench itself issued.
// Timeout scenarios are compiled in only when ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_sensor_bus_arbiter;

  localparam int NREQ        = 4;
  localparam int CMD_W       = 32;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 16;

  logic                  clk_clk = 1'b0;
  logic                  reset_reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*CMD_W-1:0] req_cmd;
  logic [NREQ-1:0]       req_ack;
  logic                  req_err;
  logic [DATA_W-1:0]     rsp_data;
  logic [NREQ-1:0]       cur_grant;
  logic                  busy;
  logic                  eng_ready;
  logic                  eng_start;
  logic [CMD_W-1:0]      eng_cmd;
  logic                  eng_done;
  logic [DATA_W-1:0]     eng_rdata;
  logic                  eng_abort;

  always #5 clk_clk = ~clk_clk;

  sensor_bus_arbiter #(
    .NREQ        (NREQ),
    .CMD_W       (CMD_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .req_valid     (req_valid),
    .req_cmd       (req_cmd),
    .req_ack       (req_ack),
    .req_err       (req_err),
    .rsp_data      (rsp_data),
    .cur_grant     (cur_grant),
    .busy          (busy),
    .eng_ready     (eng_ready),
    .eng_start     (eng_start),
    .eng_cmd       (eng_cmd),
    .eng_done      (eng_done),
    .eng_rdata     (eng_rdata),
    .eng_abort     (eng_abort)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Event tallies sampled mid-cycle, compared against bench expectations.
  int n_start = 0, n_ack = 0, n_abort = 0;
  int exp_starts = 0, exp_acks = 0, exp_aborts = 0;

  // Reference model state.
  int               last_m = NREQ - 1;
  logic [CMD_W-1:0] cmd_m [NREQ];

  always @(negedge clk_clk) begin
    if (eng_start)     n_start++;
    if (req_ack != '0) n_ack++;
    if (eng_abort)     n_abort++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  // Reference arbitration: first pending requester after the last winner.
  function automatic int rr_ref(input logic [NREQ-1:0] pend, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return 0;
  endfunction

  // Raise a request with a fresh command; a pending request keeps its command.
  task automatic raise(input int i);
    if (!req_valid[i]) begin
      cmd_m[i] = $urandom;
      req_cmd[i*CMD_W +: CMD_W] = cmd_m[i];
      req_valid[i] = 1'b1;
    end
  endtask

  // Wait (bounded) for the start pulse and check the grant it carries.
  task automatic begin_txn(output int w, output int waited);
    w = rr_ref(req_valid, last_m);
    waited = 0;
    do begin
      step();
      waited++;
    end while (!eng_start && waited < 20);
    check("start_seen", eng_start, 1);
    exp_starts++;
    check("cur_grant", cur_grant, 64'(1) << w);
    check("eng_cmd", eng_cmd, cmd_m[w]);
    check("busy_issue", busy, 1);
  endtask

  // Engine completes after 'delay' further cycles; check the acknowledge.
  task automatic end_txn(input int w, input int delay, input logic [DATA_W-1:0] rd,
                         input bit hold);
    repeat (delay) step();
    eng_done  = 1'b1;
    eng_rdata = rd;
    step();
    eng_done  = 1'b0;
    eng_rdata = $urandom;
    check("req_ack", req_ack, 64'(1) << w);
    check("rsp_data", rsp_data, rd);
    check("req_err", req_err, 0);
    if (!hold) req_valid[w] = 1'b0;
    last_m = w;
    exp_acks++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, waited, base, base_abort, k, d, ns, nb;
    int fair_seq [5] = '{0, 1, 2, 3, 0};
    bit lowered;
    logic [DATA_W-1:0] rd;

    req_valid     = '0;
    req_cmd       = '0;
    eng_ready     = 1'b1;
    eng_done      = 1'b0;
    eng_rdata     = $urandom;
    reset_reset_n = 1'b0;
    for (int i = 0; i < NREQ; i++) cmd_m[i] = '0;

    // Reset state
    repeat (3) @(posedge clk_clk);
    #1;
    check("rst_ctrl", {req_ack, req_err, cur_grant, busy, eng_start, eng_abort}, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_eng_cmd", eng_cmd, 0);
    reset_reset_n = 1'b1;
    step();
    step();
    check("idle_busy", busy, 0);

    // Single request: minimum latency, exactly one start
    raise(1);
    base = n_start;
    begin_txn(w, waited);
    check("single_latency", waited, 1);
    end_txn(w, 5, 32'hA5A5_0001, 0);
    repeat (4) step();
    check("single_one_start", n_start - base, 1);

    // eng_done during ISSUE is ignored
    raise(0);
    begin_txn(w, waited);
    eng_done  = 1'b1;
    eng_rdata = 32'hDEAD_BEEF;
    step();
    eng_done  = 1'b0;
    step();
    check("issue_done_no_ack", req_ack, 0);
    check("issue_done_busy", busy, 1);
    end_txn(w, 0, 32'h0000_1234, 0);

    // Move the pointer to requester 3, then all four requesters held
    raise(3);
    begin_txn(w, waited);
    end_txn(w, 1, $urandom, 0);
    for (int i = 0; i < NREQ; i++) raise(i);
    for (int t = 0; t < 5; t++) begin
      begin_txn(w, waited);
      check("fair_order", cur_grant, 64'(1) << fair_seq[t]);
      end_txn(w, $urandom_range(1, 3), $urandom, 1);
    end
    req_valid = '0;

    // Engine not ready: nothing starts, then start one cycle after ready
    step();
    eng_ready = 1'b0;
    raise(2);
    ns = 0;
    nb = 0;
    repeat (10) begin
      step();
      ns += int'(eng_start);
      nb += int'(busy);
    end
    check("notready_starts", ns, 0);
    check("notready_busy", nb, 0);
    eng_ready = 1'b1;
    begin_txn(w, waited);
    check("ready_latency", waited, 1);
    end_txn(w, 3, $urandom, 0);

    // Request withdrawn during WAIT still completes, acked once
    step();
    raise(2);
    base = n_ack;
    begin_txn(w, waited);
    step();
    req_valid[2] = 1'b0;
    end_txn(w, 3, $urandom, 0);
    repeat (8) step();
    check("withdraw_single_ack", n_ack - base, 1);
    check("withdraw_idle", busy, 0);

`ifdef ARB_TIMEOUT_EN
    // Timeout: abort in the last WAIT cycle, then an error acknowledge
    step();
    raise(0);
    base_abort = n_abort;
    begin_txn(w, waited);
    eng_rdata = 32'hFFFF_FFFF;
    k = 0;
    while (!eng_abort && k < 40) begin
      step();
      k++;
    end
    check("to_abort_cycle", k, TIMEOUT_CYC);
    check("to_no_ack_yet", req_ack, 0);
    step();
    check("to_ack", req_ack, 64'(1) << w);
    check("to_err", req_err, 1);
    check("to_rsp_zero", rsp_data, 0);
    req_valid[w] = 1'b0;
    last_m = w;
    exp_acks++;
    exp_aborts++;
    step();
    step();
    check("to_abort_once", n_abort - base_abort, 1);

    // eng_done in the timeout cycle wins
    raise(1);
    begin_txn(w, waited);
    repeat (TIMEOUT_CYC) step();
    rd        = $urandom;
    eng_done  = 1'b1;
    eng_rdata = rd;
    #1;
    check("to_done_wins_abort", eng_abort, 0);
    end_txn(w, 0, rd, 0);
    step();
    check("to_done_wins_count", n_abort - base_abort, 1);
`endif

    // Reset during WAIT: outputs clear at once, no ack, requester 0 first
    step();
    raise(2);
    begin_txn(w, waited);
    step();
    step();
    base = n_ack;
    #2;
    reset_reset_n = 1'b0;
    #1;
    check("midrst_ctrl", {req_ack, req_err, cur_grant, busy, eng_start, eng_abort}, 0);
    check("midrst_rsp_data", rsp_data, 0);
    check("midrst_eng_cmd", eng_cmd, 0);
    req_valid = '0;
    eng_done  = 1'b0;
    step();
    step();
    reset_reset_n = 1'b1;
    last_m = NREQ - 1;
    check("midrst_no_ack", n_ack - base, 0);
    raise(0);
    raise(3);
    begin_txn(w, waited);
    check("midrst_first_grant", cur_grant, 4'b0001);
    end_txn(w, 2, $urandom, 0);
    begin_txn(w, waited);
    end_txn(w, 2, $urandom, 0);

    // Randomized traffic against the reference model
    for (int it = 0; it < 30; it++) begin
      if (req_valid == '0 || $urandom_range(0, 1) == 1) raise($urandom_range(0, NREQ - 1));
      lowered = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        lowered   = 1'b1;
        eng_ready = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        eng_ready = 1'b1;
      end
      begin_txn(w, waited);
      if (!lowered && it > 0) check("b2b_gap", waited, 2);
      d = $urandom_range(2, 7);
      step();
      if ($urandom_range(0, 3) == 0) req_valid[w] = 1'b0;
      if ($urandom_range(0, 1) == 1) raise($urandom_range(0, NREQ - 1));
      rd = $urandom;
      end_txn(w, d - 1, rd, 0);
    end
    req_valid = '0;

    // Totals
    repeat (4) step();
    check("total_starts", n_start, exp_starts);
    check("total_acks", n_ack, exp_acks);
    check("total_aborts", n_abort, exp_aborts);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sensor_bus_arbiter

// File: doc/sensor_bus_arbiter.md
SENSOR_BUS_ARBITER -- requirements
Module: sensor_bus_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one serial transaction engine (I2C or SPI master).
REQ-002 SHALL have parameter CMD_W, default 32: command word width.
REQ-003 SHALL have parameter DATA_W, default 32: read-data width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 65535: engine completion timeout in clk_clk cycles.
REQ-005 SHALL have port clk_clk  in  1: single clock; all logic rising-edge.
REQ-006 SHALL have port reset_reset_n  in  1: asynchronous active-low reset.
REQ-007 SHALL have port req_valid  in  NREQ: per-requester request, held until its ack.
REQ-008 SHALL have port req_cmd  in  NREQ*CMD_W: packed commands, requester i at bits [i*CMD_W +: CMD_W].
REQ-009 SHALL have port req_ack  out  NREQ: one-hot, one-cycle completion pulse.
REQ-010 SHALL have port req_err  out  1: qualifies req_ack; 1 = transaction timed out.
REQ-011 SHALL have port rsp_data  out  DATA_W: read data, valid while req_ack is high.
REQ-012 SHALL have port cur_grant  out  NREQ: one-hot owner of the engine, 0 when idle.
REQ-013 SHALL have port busy  out  1: high in every state except IDLE.
REQ-014 SHALL have port eng_ready  in  1: engine idle and able to accept a start.
REQ-015 SHALL have port eng_start  out  1: one-cycle start pulse.
REQ-016 SHALL have port eng_cmd  out  CMD_W: latched command, stable from ISSUE until RESP ends.
REQ-017 SHALL have port eng_done  in  1: one-cycle completion from the engine.
REQ-018 SHALL have port eng_rdata  in  DATA_W: engine read data, valid with eng_done.
REQ-019 SHALL have port eng_abort  out  1: one-cycle abort pulse on timeout.

Function
REQ-020 SHALL use the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-021 IDLE: if any req_valid bit is set and eng_ready=1, SHALL select the winner, latch its index and command, and move to ISSUE; otherwise SHALL stay in IDLE.
REQ-022 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NREQ and wraps; after reset last_grant = NREQ-1, so requester 0 has first priority.
REQ-023 ISSUE: SHALL drive eng_start=1 for exactly one cycle, clear the timeout counter, then move to WAIT.
REQ-024 WAIT: SHALL capture eng_rdata when eng_done=1 and move to RESP; eng_done SHALL be ignored in every other state.
REQ-025 RESP: SHALL assert req_ack[grant]=1 for one cycle with rsp_data and req_err valid, update last_grant, then return to IDLE.
REQ-026 Minimum latency SHALL be: req sampled at edge k, eng_start high in cycle k+1, and req_ack in the cycle after the eng_done edge.
REQ-027 Dropping req_valid after the grant SHALL NOT cancel the transaction; it completes and the ack is still issued.
REQ-028 cur_grant SHALL be the one-hot latched index in ISSUE, WAIT and RESP, and 0 in IDLE.
REQ-029 The back-to-back gap SHALL be one IDLE cycle minimum between RESP and the next ISSUE.

Reset
REQ-030 Assertion of reset SHALL asynchronously force IDLE, set last_grant to NREQ-1, and zero req_ack, req_err, rsp_data, cur_grant, busy, eng_start, eng_cmd, eng_abort and the timeout counter.
REQ-031 Reset mid-transaction SHALL produce no ack and no abort pulse; the engine is reset by the same reset signal.

Configuration
REQ-032 With ARB_TIMEOUT_EN defined, SHALL count cycles in WAIT; at count TIMEOUT_CYC-1 without eng_done, SHALL pulse eng_abort for one cycle and enter RESP with req_err=1 and rsp_data=0.
REQ-033 With ARB_TIMEOUT_EN defined, if eng_done coincides with the timeout cycle, eng_done SHALL win: req_err=0 and no abort.
REQ-034 Without ARB_TIMEOUT_EN, SHALL have no counter, WAIT SHALL last indefinitely, eng_abort SHALL be tied 0 and req_err SHALL be tied 0.

Structure
REQ-035 A shared package SHALL hold the state enum (arb_state_t) and the default NREQ, CMD_W and DATA_W constants.
REQ-036 The round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector and last_grant; outputs: valid and index).

Verification
REQ-037 Single request: req_valid=4'b0010 with eng_ready=1, eng_done 5 cycles after start, eng_rdata=32'hA5A5_0001 -> exactly one eng_start, eng_cmd=req_cmd[1], req_ack=4'b0010, rsp_data=32'hA5A5_0001, req_err=0.
REQ-038 Fairness: req_valid=4'b1111 held continuously -> grant order 0,1,2,3,0, with no requester granted twice before all others.
REQ-039 Engine not ready: eng_ready=0 for 10 cycles with req pending -> no eng_start and busy=0; eng_start 1 cycle after eng_ready rises.
REQ-040 Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYC=16): no eng_done -> eng_abort pulse, then req_ack with req_err=1 and rsp_data=0; a second run with eng_done on cycle 15 -> req_err=0 and no abort.
REQ-041 Mid-transaction reset: reset asserted during WAIT -> all outputs 0 immediately; after release, requester 0 is granted first when req_valid=4'b1001.
REQ-042 Request withdrawn: req_valid[2] deasserted during WAIT -> req_ack[2] still pulses once, and no stray ack follows.
